// File: rtl/traffic_remote_console.sv
// traffic_remote_console
// Far-end console for the traffic light controller UART link. Sits between a
// uart_rx / uart_tx byte pair: parses two-byte telemetry frames (status char +
// ASCII timer digit), runs a link watchdog, and sends single-byte commands that
// are confirmed by watching later telemetry frames.
// Build option: define CMD_RETRY_EN to resend an unconfirmed command up to
// RESEND_LIMIT total attempts; without it the first unconfirmed attempt fails.

module traffic_remote_console #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int LINK_TIMEOUT_S = 3,
    parameter int CONFIRM_FRAMES = 2,
    parameter int RESEND_LIMIT   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       cmd_req,
    input  logic [2:0] cmd_sel,
    output logic       cmd_pending,
    output logic       cmd_ok,
    output logic       cmd_fail,
    output logic [7:0] remote_status,
    output logic [3:0] remote_timer,
    output logic       frame_valid,
    output logic       link_up,
    output logic [7:0] proto_err
);

    // Last watchdog count value; reaching it without a commit drops the link.
    localparam logic [31:0] WD_LAST = 32'(LINK_TIMEOUT_S * CLK_HZ - 1);
    localparam int FC_W = $clog2(CONFIRM_FRAMES + 1);
    // Attempt counter is sized for the largest retry budget in either build.
    localparam int AT_W = $clog2(RESEND_LIMIT + 1);

`ifdef CMD_RETRY_EN
    localparam int MAX_ATTEMPTS = RESEND_LIMIT;
`else
    localparam int MAX_ATTEMPTS = 1;
`endif

    typedef enum logic {
        P_WAIT_STATUS = 1'b0,
        P_WAIT_DIGIT  = 1'b1
    } p_state_t;

    typedef enum logic [2:0] {
        T_IDLE      = 3'd0,
        T_SEND      = 3'd1,
        T_WAIT_BUSY = 3'd2,
        T_WAIT_DONE = 3'd3,
        T_CONFIRM   = 3'd4
    } t_state_t;

    function automatic logic is_status(input logic [7:0] b);
        case (b)
            8'h43, 8'h4E, 8'h53, 8'h45, 8'h57: is_status = 1'b1;
            default:                           is_status = 1'b0;
        endcase
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        is_digit = (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic logic [7:0] cmd_char(input logic [2:0] sel);
        case (sel)
            3'd0:    cmd_char = 8'h43;
            3'd1:    cmd_char = 8'h4E;
            3'd2:    cmd_char = 8'h53;
            3'd3:    cmd_char = 8'h45;
            3'd4:    cmd_char = 8'h57;
            default: cmd_char = 8'h43;
        endcase
    endfunction

    // ---------------- frame parser ----------------
    p_state_t    p_state_r, p_state_s;
    logic [7:0]  status_hold_r, status_hold_s;
    logic        commit_s;
    logic        perr_inc_s;
    logic [7:0]  remote_status_r;
    logic [3:0]  remote_timer_r;
    logic        frame_valid_r;
    logic [7:0]  proto_err_r;

    // Parser next-state: classify the received byte against the expected field.
    always_comb begin
        p_state_s     = p_state_r;
        status_hold_s = status_hold_r;
        commit_s      = 1'b0;
        perr_inc_s    = 1'b0;
        if (rx_done) begin
            case (p_state_r)
                P_WAIT_STATUS: begin
                    if (is_status(rx_data)) begin
                        status_hold_s = rx_data;
                        p_state_s     = P_WAIT_DIGIT;
                    end else begin
                        perr_inc_s = 1'b1;
                    end
                end
                P_WAIT_DIGIT: begin
                    if (is_digit(rx_data)) begin
                        commit_s  = 1'b1;
                        p_state_s = P_WAIT_STATUS;
                    end else if (is_status(rx_data)) begin
                        // A fresh status byte resyncs onto a new frame.
                        perr_inc_s    = 1'b1;
                        status_hold_s = rx_data;
                    end else begin
                        perr_inc_s = 1'b1;
                        p_state_s  = P_WAIT_STATUS;
                    end
                end
                default: begin
                    p_state_s = P_WAIT_STATUS;
                end
            endcase
        end else begin
            p_state_s = p_state_r;
        end
    end

    // Parser registers, committed telemetry and saturating error count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_state_r       <= P_WAIT_STATUS;
            status_hold_r   <= 8'h00;
            remote_status_r <= 8'h43;
            remote_timer_r  <= 4'h0;
            frame_valid_r   <= 1'b0;
            proto_err_r     <= 8'h00;
        end else begin
            p_state_r     <= p_state_s;
            status_hold_r <= status_hold_s;
            frame_valid_r <= commit_s;
            if (commit_s) begin
                remote_status_r <= status_hold_r;
                // For 0x30-0x39 the low nibble equals rx_data - 0x30.
                remote_timer_r  <= rx_data[3:0];
            end
            if (perr_inc_s && (proto_err_r != 8'hFF)) begin
                proto_err_r <= proto_err_r + 8'd1;
            end
        end
    end

    // ---------------- link watchdog ----------------
    logic [31:0] wd_cnt_r;
    logic        link_up_r;
    logic        wd_expire_s;

    // True on the cycle whose clock edge drops link_up.
    assign wd_expire_s = link_up_r && !commit_s && (wd_cnt_r == WD_LAST);

    // Watchdog: restart on every frame commit, hold once the window expires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt_r  <= 32'd0;
            link_up_r <= 1'b0;
        end else if (commit_s) begin
            wd_cnt_r  <= 32'd0;
            link_up_r <= 1'b1;
        end else if (wd_cnt_r == WD_LAST) begin
            link_up_r <= 1'b0;
        end else begin
            wd_cnt_r <= wd_cnt_r + 32'd1;
        end
    end

    // ---------------- command transmit / confirm ----------------
    t_state_t          t_state_r, t_state_s;
    logic [7:0]        code_r, code_s;
    logic [AT_W-1:0]   attempt_r, attempt_s;
    logic [FC_W-1:0]   fcnt_r, fcnt_s;
    logic              cmd_pending_r, cmd_pending_s;
    logic [7:0]        tx_data_r, tx_data_s;
    logic              tx_start_r, tx_start_s;
    logic              cmd_ok_r, cmd_ok_s;
    logic              cmd_fail_r, cmd_fail_s;

    // Command FSM next-state; a link loss aborts any in-flight command first.
    always_comb begin
        t_state_s     = t_state_r;
        code_s        = code_r;
        attempt_s     = attempt_r;
        fcnt_s        = fcnt_r;
        cmd_pending_s = cmd_pending_r;
        tx_data_s     = tx_data_r;
        tx_start_s    = 1'b0;
        cmd_ok_s      = 1'b0;
        cmd_fail_s    = 1'b0;
        if (wd_expire_s && cmd_pending_r) begin
            cmd_fail_s    = 1'b1;
            cmd_pending_s = 1'b0;
            t_state_s     = T_IDLE;
        end else begin
            case (t_state_r)
                T_IDLE: begin
                    if (cmd_req) begin
                        if (cmd_sel <= 3'd4) begin
                            code_s        = cmd_char(cmd_sel);
                            cmd_pending_s = 1'b1;
                            attempt_s     = AT_W'(1);
                            t_state_s     = T_SEND;
                        end else begin
                            cmd_fail_s = 1'b1;
                        end
                    end else begin
                        t_state_s = T_IDLE;
                    end
                end
                T_SEND: begin
                    if (!tx_busy) begin
                        tx_data_s  = code_r;
                        tx_start_s = 1'b1;
                        t_state_s  = T_WAIT_BUSY;
                    end else begin
                        t_state_s = T_SEND;
                    end
                end
                T_WAIT_BUSY: begin
                    if (tx_busy) begin
                        t_state_s = T_WAIT_DONE;
                    end else begin
                        t_state_s = T_WAIT_BUSY;
                    end
                end
                T_WAIT_DONE: begin
                    if (!tx_busy) begin
                        fcnt_s    = '0;
                        t_state_s = T_CONFIRM;
                    end else begin
                        t_state_s = T_WAIT_DONE;
                    end
                end
                T_CONFIRM: begin
                    if (frame_valid_r) begin
                        if (remote_status_r == code_r) begin
                            cmd_ok_s      = 1'b1;
                            cmd_pending_s = 1'b0;
                            t_state_s     = T_IDLE;
                        end else if ((fcnt_r + FC_W'(1)) == FC_W'(CONFIRM_FRAMES)) begin
                            if (attempt_r < AT_W'(MAX_ATTEMPTS)) begin
                                attempt_s = attempt_r + AT_W'(1);
                                fcnt_s    = '0;
                                t_state_s = T_SEND;
                            end else begin
                                cmd_fail_s    = 1'b1;
                                cmd_pending_s = 1'b0;
                                t_state_s     = T_IDLE;
                            end
                        end else begin
                            fcnt_s = fcnt_r + FC_W'(1);
                        end
                    end else begin
                        t_state_s = T_CONFIRM;
                    end
                end
                default: begin
                    cmd_pending_s = 1'b0;
                    t_state_s     = T_IDLE;
                end
            endcase
        end
    end

    // Command FSM state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_state_r     <= T_IDLE;
            code_r        <= 8'h00;
            attempt_r     <= '0;
            fcnt_r        <= '0;
            cmd_pending_r <= 1'b0;
            tx_data_r     <= 8'h00;
            tx_start_r    <= 1'b0;
            cmd_ok_r      <= 1'b0;
            cmd_fail_r    <= 1'b0;
        end else begin
            t_state_r     <= t_state_s;
            code_r        <= code_s;
            attempt_r     <= attempt_s;
            fcnt_r        <= fcnt_s;
            cmd_pending_r <= cmd_pending_s;
            tx_data_r     <= tx_data_s;
            tx_start_r    <= tx_start_s;
            cmd_ok_r      <= cmd_ok_s;
            cmd_fail_r    <= cmd_fail_s;
        end
    end

    assign tx_data       = tx_data_r;
    assign tx_start      = tx_start_r;
    assign cmd_pending   = cmd_pending_r;
    assign cmd_ok        = cmd_ok_r;
    assign cmd_fail      = cmd_fail_r;
    assign remote_status = remote_status_r;
    assign remote_timer  = remote_timer_r;
    assign frame_valid   = frame_valid_r;
    assign link_up       = link_up_r;
    assign proto_err     = proto_err_r;

endmodule

// File: tb/tb_traffic_remote_console.sv
// Testbench for traffic_remote_console: directed plus randomized rx traffic and
// commands, checked against a behavioural model of frames and command outcomes.
// A second instance with a 100-cycle link timeout exercises the watchdog.

module tb_traffic_remote_console;

    localparam int BIT_CYC  = 434;
    localparam int BYTE_CYC = BIT_CYC * 10;
    localparam int CONFIRM  = 2;
    localparam int RESEND   = 3;
`ifdef CMD_RETRY_EN
    localparam int MAX_ATT = RESEND;
`else
    localparam int MAX_ATT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       cmd_req;
    logic [2:0] cmd_sel;
    logic       cmd_pending, cmd_ok, cmd_fail;
    logic [7:0] remote_status;
    logic [3:0] remote_timer;
    logic       frame_valid, link_up;
    logic [7:0] proto_err;

    logic [7:0] w_rx_data;
    logic       w_rx_done, w_tx_busy;
    logic [7:0] w_tx_data;
    logic       w_tx_start, w_cmd_req;
    logic [2:0] w_cmd_sel;
    logic       w_cmd_pending, w_cmd_ok, w_cmd_fail;
    logic [7:0] w_remote_status;
    logic [3:0] w_remote_timer;
    logic       w_frame_valid, w_link_up;
    logic [7:0] w_proto_err;

    traffic_remote_console #(
        .CLK_HZ(50_000_000), .LINK_TIMEOUT_S(3),
        .CONFIRM_FRAMES(CONFIRM), .RESEND_LIMIT(RESEND)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
        .cmd_req(cmd_req), .cmd_sel(cmd_sel), .cmd_pending(cmd_pending),
        .cmd_ok(cmd_ok), .cmd_fail(cmd_fail), .remote_status(remote_status),
        .remote_timer(remote_timer), .frame_valid(frame_valid),
        .link_up(link_up), .proto_err(proto_err)
    );

    traffic_remote_console #(
        .CLK_HZ(100), .LINK_TIMEOUT_S(1),
        .CONFIRM_FRAMES(CONFIRM), .RESEND_LIMIT(RESEND)
    ) dut_wd (
        .clk(clk), .rst_n(rst_n), .rx_data(w_rx_data), .rx_done(w_rx_done),
        .tx_busy(w_tx_busy), .tx_data(w_tx_data), .tx_start(w_tx_start),
        .cmd_req(w_cmd_req), .cmd_sel(w_cmd_sel), .cmd_pending(w_cmd_pending),
        .cmd_ok(w_cmd_ok), .cmd_fail(w_cmd_fail), .remote_status(w_remote_status),
        .remote_timer(w_remote_timer), .frame_valid(w_frame_valid),
        .link_up(w_link_up), .proto_err(w_proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Observed event counts from the uart_tx model / monitor.
    int         n_starts = 0;
    int         n_ok     = 0;
    int         n_cfail  = 0;
    int         n_viol   = 0;
    int         busy_left = 0;
    logic [7:0] last_tx  = 8'h00;

    // Expected counts.
    int exp_ok    = 0;
    int exp_cfail = 0;

    // Parser reference model.
    logic       m_have;
    logic [7:0] m_hold;
    logic [7:0] m_status;
    logic [3:0] m_timer;
    int         m_err;

    logic [7:0] codes [5] = '{8'h43, 8'h4E, 8'h53, 8'h45, 8'h57};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic in_status_set(input logic [7:0] b);
        in_status_set = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (codes[i] == b) in_status_set = 1'b1;
        end
    endfunction

    // Model one received byte; returns 1 when it completes a frame.
    function automatic logic model_rx(input logic [7:0] b);
        logic dig;
        dig = (b >= 8'h30) && (b <= 8'h39);
        model_rx = 1'b0;
        if (!m_have) begin
            if (in_status_set(b)) begin m_have = 1'b1; m_hold = b; end
            else m_err++;
        end else if (dig) begin
            m_status = m_hold;
            m_timer  = 4'(int'(b) - 48);
            m_have   = 1'b0;
            model_rx = 1'b1;
        end else if (in_status_set(b)) begin
            m_err++;
            m_hold = b;
        end else begin
            m_err++;
            m_have = 1'b0;
        end
    endfunction

    task automatic check_parser(input logic exp_fv);
        check("frame_valid", frame_valid, exp_fv);
        check("remote_status", remote_status, m_status);
        check("remote_timer", remote_timer, m_timer);
        check("proto_err", proto_err, (m_err > 255) ? 255 : m_err);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        logic fv;
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        fv = model_rx(b);
        check_parser(fv);
    endtask

    task automatic frame(input logic [7:0] st, input logic [7:0] dg);
        rx_byte(st);
        rx_byte(dg);
    endtask

    task automatic cmd(input logic [2:0] sel);
        @(negedge clk);
        cmd_sel = sel;
        cmd_req = 1'b1;
        @(negedge clk);
        cmd_req = 1'b0;
    endtask

    // Wait (bounded) until the expected number of transmissions has finished.
    task automatic wait_tx(input int exp);
        int guard;
        guard = 0;
        while ((n_starts < exp || tx_busy) && guard < 3 * BYTE_CYC) begin
            @(negedge clk);
            guard++;
        end
        idle(2);
        check("tx_start_count", n_starts, exp);
    endtask

    // uart_tx model and output monitor, sampled on the falling edge.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_ok === 1'b1) n_ok++;
            if (cmd_fail === 1'b1) n_cfail++;
            if (tx_start === 1'b1) begin
                n_starts++;
                last_tx = tx_data;
                if (tx_busy) n_viol++;
                tx_busy   = 1'b1;
                busy_left = BYTE_CYC;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end
        end
    end

    initial begin
        int         base;
        int         att;
        int         mism;
        int         wd_early;
        logic       done;
        logic       fv;
        logic [2:0] sel;
        logic [7:0] code;
        logic [7:0] st;
        logic [7:0] b;

        rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; cmd_req = 1'b0; cmd_sel = 3'd0;
        w_rx_data = 8'h00; w_rx_done = 1'b0; w_tx_busy = 1'b0; w_cmd_req = 1'b0; w_cmd_sel = 3'd0;
        m_have = 1'b0; m_hold = 8'h00; m_status = 8'h43; m_timer = 4'd0; m_err = 0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_remote_status", remote_status, 8'h43);
        check("rst_link_up", link_up, 1'b0);
        check("rst_proto_err", proto_err, 8'h00);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_cmd_pending", cmd_pending, 1'b0);
        check("rst_frame_valid", frame_valid, 1'b0);
        rst_n = 1'b1;

        // Basic frame.
        frame(8'h4E, 8'h37);
        check("basic_timer", remote_timer, 4'd7);
        check("basic_link_up", link_up, 1'b1);

        // Error / resync sequence.
        rx_byte(8'h58);
        frame(8'h4E, 8'h53);
        rx_byte(8'h35);
        rx_byte(8'h45);
        rx_byte(8'h41);
        check("err_seq_proto_err", proto_err, 8'd3);
        check("err_seq_status", remote_status, 8'h53);
        check("err_seq_timer", remote_timer, 4'd5);
        rx_byte(8'h31);   // a digit in WAIT_STATUS is an error

        // Random byte stream.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       b = codes[$urandom_range(0, 4)];
                1:       b = 8'(8'h30 + $urandom_range(0, 9));
                default: b = 8'($urandom_range(0, 255));
            endcase
            rx_byte(b);
        end

        // Command 'E' confirmed; a second request in flight is ignored.
        base = n_starts;
        cmd(3'd3);
        check("e_pending", cmd_pending, 1'b1);
        idle(5);
        cmd(3'd0);
        wait_tx(base + 1);
        check("e_tx_data", last_tx, 8'h45);
        check("e_still_pending", cmd_pending, 1'b1);
        frame(8'h45, 8'h39);
        idle(3);
        exp_ok++;
        check("e_cmd_ok", n_ok, exp_ok);
        check("e_pending_clr", cmd_pending, 1'b0);
        idle(20);
        check("e_no_extra_tx", n_starts, base + 1);

        // Command 'N' answered only by 'C' frames.
        base = n_starts;
        cmd(3'd1);
        for (int a = 1; a <= MAX_ATT; a++) begin
            wait_tx(base + a);
            check("n_tx_data", last_tx, 8'h4E);
            frame(8'h43, 8'h33);
            idle(3);
            check("n_no_fail_yet", n_cfail, exp_cfail);
            frame(8'h43, 8'h33);
            idle(3);
            if (a == MAX_ATT) exp_cfail++;
            check("n_fail_count", n_cfail, exp_cfail);
        end
        idle(20);
        check("n_total_tx", n_starts, base + MAX_ATT);
        check("n_pending_clr", cmd_pending, 1'b0);

        // Invalid selects.
        base = n_starts;
        for (int s = 5; s <= 7; s++) begin
            cmd(3'(s));
            idle(2);
            exp_cfail++;
            check("bad_sel_fail", n_cfail, exp_cfail);
            check("bad_sel_pending", cmd_pending, 1'b0);
        end
        check("bad_sel_no_tx", n_starts, base);

        // Frame committing on the acceptance cycle does not confirm.
        rx_byte(8'h57);
        base = n_starts;
        @(negedge clk);
        rx_data = 8'h30; rx_done = 1'b1; cmd_sel = 3'd4; cmd_req = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0; cmd_req = 1'b0;
        fv = model_rx(8'h30);
        check_parser(fv);
        idle(5);
        check("same_cycle_no_ok", n_ok, exp_ok);
        check("same_cycle_pending", cmd_pending, 1'b1);
        wait_tx(base + 1);
        frame(8'h57, 8'h32);
        idle(3);
        exp_ok++;
        check("same_cycle_later_ok", n_ok, exp_ok);

        // Randomized commands against the outcome model.
        for (int c = 0; c < 2; c++) begin
            sel  = 3'($urandom_range(0, 4));
            code = codes[sel];
            base = n_starts;
            cmd(sel);
            done = 1'b0;
            att  = 0;
            while (!done && att < MAX_ATT) begin
                att++;
                wait_tx(base + att);
                check("rnd_tx_data", last_tx, code);
                mism = 0;
                while (!done && mism < CONFIRM) begin
                    if ($urandom_range(0, 2) == 0) st = code;
                    else st = codes[(int'(sel) + 1 + $urandom_range(0, 3)) % 5];
                    frame(st, 8'(8'h30 + $urandom_range(0, 9)));
                    idle(3);
                    if (st == code) begin
                        exp_ok++;
                        done = 1'b1;
                    end else begin
                        mism++;
                        if (mism == CONFIRM && att == MAX_ATT) begin
                            exp_cfail++;
                            done = 1'b1;
                        end
                    end
                end
            end
            idle(3);
            check("rnd_ok", n_ok, exp_ok);
            check("rnd_fail", n_cfail, exp_cfail);
            check("rnd_pending", cmd_pending, 1'b0);
            check("rnd_tx_total", n_starts, base + att);
        end

        check("tx_start_while_busy", n_viol, 0);

        // Watchdog: 100-cycle window, pending command aborted on link loss.
        @(negedge clk);
        w_cmd_sel = 3'd2; w_cmd_req = 1'b1;
        @(negedge clk);
        w_cmd_req = 1'b0;
        idle(3);
        check("wd_pending", w_cmd_pending, 1'b1);
        @(negedge clk);
        w_rx_data = 8'h53; w_rx_done = 1'b1;
        @(negedge clk);
        w_rx_data = 8'h34;
        @(posedge clk);
        #1;
        w_rx_done = 1'b0;
        check("wd_link_up", w_link_up, 1'b1);
        check("wd_frame_valid", w_frame_valid, 1'b1);
        wd_early = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (i < 100 && (w_link_up !== 1'b1 || w_cmd_fail !== 1'b0)) wd_early++;
        end
        check("wd_early_drop", wd_early, 0);
        check("wd_link_down", w_link_up, 1'b0);
        check("wd_cmd_fail", w_cmd_fail, 1'b1);
        check("wd_pending_clr", w_cmd_pending, 1'b0);
        @(posedge clk);
        #1;
        check("wd_fail_pulse", w_cmd_fail, 1'b0);
        check("wd_stays_down", w_link_up, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
